uart_tx_fifo: RTL and testbench

//  Parametrised successor to the team's 8N1 UART transmitter: configurable data width, parity and stop bits,

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and parity mode codes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty/level and a one-cycle overflow pulse on a rejected write.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [LVL_W-1:0] w_level_next;

    // A write into a full queue is refused even if a pop happens on the same edge.
    assign w_wr_ok      = wr_en & ~r_full;
    assign w_rd_ok      = rd_en & ~r_empty;
    assign w_level_next = r_level + LVL_W'(w_wr_ok) - LVL_W'(w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_next;
            r_full     <= (w_level_next == LVL_W'(DEPTH));
            r_empty    <= (w_level_next == '0);
            r_overflow <= wr_en & r_full;
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data/parity/stop framing fed from a write queue; bit timing from clken.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic                          clken,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          Tx,
    output logic                          Tx_busy
);

    localparam int CNT_W = $clog2(DATA_BITS);

    generate
        if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     w_bit_cnt_next;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_par;
    logic                 w_par_next;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_word_par;
    logic                 w_bit_last;
    logic                 w_stop_last;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_50m),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (data_in),
        .rd_en    (w_pop),
        .rd_data  (w_fifo_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // Parity is latched at load time because the shift register consumes the word.
    assign w_word_par  = (PARITY == PARITY_EVEN) ? ^w_fifo_data : ~^w_fifo_data;
    assign w_bit_last  = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
    assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = r_tx;
        w_par_next      = r_par;
        w_pop           = 1'b0;
        if (clken) begin
            unique case (r_state)
                IDLE: begin
                    w_tx_next = 1'b1;
                    if (!empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
                        w_par_next   = w_word_par;
                        w_tx_next    = 1'b0;
                        w_state_next = START;
                    end
                end
                START: begin
                    w_tx_next      = r_shift[0];
                    w_bit_cnt_next = '0;
                    w_state_next   = DATA;
                end
                DATA: begin
                    if (w_bit_last) begin
                        if (PARITY != PARITY_NONE) begin
                            w_tx_next    = r_par;
                            w_state_next = uart_pkg::PARITY;
                        end else begin
                            w_tx_next       = 1'b1;
                            w_stop_cnt_next = 1'b0;
                            w_state_next    = STOP;
                        end
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_tx_next      = r_shift[1];
                    end
                end
                uart_pkg::PARITY: begin
                    w_tx_next       = 1'b1;
                    w_stop_cnt_next = 1'b0;
                    w_state_next    = STOP;
                end
                STOP: begin
                    w_tx_next = 1'b1;
                    if (w_stop_last) begin
                        if (!empty) begin
                            w_pop        = 1'b1;
                            w_shift_next = w_fifo_data;
                            w_par_next   = w_word_par;
                            w_tx_next    = 1'b0;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    w_tx_next    = 1'b1;
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_par      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_par      <= w_par_next;
        end
    end

    assign Tx      = r_tx;
    assign Tx_busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line samples taken once per bit period are matched against frames built from the word values.
module tb_uart_tx_fifo;

    typedef logic bitq_t[$];

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       clken;
    logic [7:0] d8Data;
    logic       d8Wr;
    logic       d8Full, d8Empty, d8Ovf, d8Tx, d8Busy;
    logic [2:0] d8Level;
    logic [6:0] d7Data;
    logic       d7Wr;
    logic       eFull, eEmpty, eOvf, eTx, eBusy;
    logic [2:0] eLevel;
    logic       oFull, oEmpty, oOvf, oTx, oBusy;
    logic [2:0] oLevel;

    int    assertCount = 0;
    int    failCount   = 0;
    int    clkDiv      = 16;
    int    cnt         = 0;
    logic  tickPrev    = 1'b0;
    bitq_t cap8, busy8, capE, capO;

    always #5 clk_50m = ~clk_50m;

    uart_tx_fifo u_dut8 (
        .clk_50m (clk_50m), .rst_n (rst_n), .clken (clken),
        .data_in (d8Data), .wr_en (d8Wr),
        .full (d8Full), .empty (d8Empty), .level (d8Level), .overflow (d8Ovf),
        .Tx (d8Tx), .Tx_busy (d8Busy)
    );

    uart_tx_fifo #(.DATA_BITS (7), .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4)) u_dutEven (
        .clk_50m (clk_50m), .rst_n (rst_n), .clken (clken),
        .data_in (d7Data), .wr_en (d7Wr),
        .full (eFull), .empty (eEmpty), .level (eLevel), .overflow (eOvf),
        .Tx (eTx), .Tx_busy (eBusy)
    );

    uart_tx_fifo #(.DATA_BITS (7), .PARITY (1), .STOP_BITS (2), .FIFO_DEPTH (4)) u_dutOdd (
        .clk_50m (clk_50m), .rst_n (rst_n), .clken (clken),
        .data_in (d7Data), .wr_en (d7Wr),
        .full (oFull), .empty (oEmpty), .level (oLevel), .overflow (oOvf),
        .Tx (oTx), .Tx_busy (oBusy)
    );

    // Baud enable: cnt names the enable phase of the posedge just past; updated just after each negedge.
    initial begin
        clken = 1'b0;
        forever begin
            @(negedge clk_50m);
            #1;
            cnt   = (cnt + 1 >= clkDiv) ? 0 : cnt + 1;
            clken = (cnt == 0);
        end
    end

    always @(posedge clk_50m) tickPrev <= clken;

    // One line sample per bit period, taken mid-cycle after every enabled edge.
    initial begin
        forever begin
            @(negedge clk_50m);
            if (tickPrev) begin
                cap8.push_back(d8Tx);
                busy8.push_back(d8Busy);
                capE.push_back(eTx);
                capO.push_back(oTx);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line levels for one frame: start, data LSB first, optional parity, stop bits.
    function automatic bitq_t frameBits(input int w, input int nBits, input int par, input int nStop);
        bitq_t q;
        int    ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < nBits; i++) begin
            q.push_back(((w >> i) & 1) != 0);
            ones += (w >> i) & 1;
        end
        if (par == 2) q.push_back((ones % 2) == 1);
        else if (par == 1) q.push_back((ones % 2) == 0);
        for (int i = 0; i < nStop; i++) q.push_back(1'b1);
        return q;
    endfunction

    // Position of the first sample disagreeing with the expected frames, or -1.
    // Idle highs are tolerated before the first frame, after the last, and between frames when frameLen > 0.
    function automatic int streamDiff(input bitq_t cap, input bitq_t expQ, input int frameLen);
        int p = 0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i == 0 || (frameLen > 0 && (i % frameLen) == 0)) begin
                while (p < cap.size() && cap[p] === 1'b1) p++;
            end
            if (p >= cap.size()) return p;
            if (cap[p] !== expQ[i]) return p;
            p++;
        end
        for (; p < cap.size(); p++) begin
            if (cap[p] !== 1'b1) return p;
        end
        return -1;
    endfunction

    function automatic int firstLow(input bitq_t q);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] !== 1'b1) return i;
        end
        return -1;
    endfunction

    task automatic clearCaps();
        cap8.delete();
        busy8.delete();
        capE.delete();
        capO.delete();
    endtask

    task automatic waitCnt(input int v);
        for (int g = 0; g < 64; g++) begin
            @(negedge clk_50m);
            if (cnt == v) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        assertCount++;
        if (d8Tx !== 1'b1) begin failCount++; $display("[TB] FAIL reset_tx: got %b want 1", d8Tx); end
        assertCount++;
        if (d8Busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b want 0", d8Busy); end
        assertCount++;
        if (d8Full !== 1'b0) begin failCount++; $display("[TB] FAIL reset_full: got %b want 0", d8Full); end
        assertCount++;
        if (d8Empty !== 1'b1) begin failCount++; $display("[TB] FAIL reset_empty: got %b want 1", d8Empty); end
        assertCount++;
        if (d8Level !== 3'd0) begin failCount++; $display("[TB] FAIL reset_level: got %0d want 0", d8Level); end
        assertCount++;
        if (d8Ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b want 0", d8Ovf); end
        assertCount++;
        if ({eTx, eBusy, eFull, eEmpty, eLevel, eOvf} !== 8'b1001_0000) begin
            failCount++;
            $display("[TB] FAIL reset_even_dut: got %b want 10010000", {eTx, eBusy, eFull, eEmpty, eLevel, eOvf});
        end
        assertCount++;
        if ({oTx, oBusy, oFull, oEmpty, oLevel, oOvf} !== 8'b1001_0000) begin
            failCount++;
            $display("[TB] FAIL reset_odd_dut: got %b want 10010000", {oTx, oBusy, oFull, oEmpty, oLevel, oOvf});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);
    endtask

    task automatic test_frame_8n1();
        bitq_t expQ;
        int    d, s;
        expQ = frameBits(8'hA5, 8, 0, 1);
        waitCnt(0);
        @(negedge clk_50m);
        clearCaps();
        d8Data = 8'hA5;
        d8Wr   = 1'b1;
        @(negedge clk_50m);
        d8Wr   = 1'b0;
        repeat (13 * 16) @(negedge clk_50m);
        d = streamDiff(cap8, expQ, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL frame_a5: first bad sample %0d, want none (-1)", d); end
        s = firstLow(cap8);
        assertCount++;
        if (s !== 0) begin failCount++; $display("[TB] FAIL start_latency: start at period %0d want 0", s); end
        assertCount++;
        if (s < 0 || s + 10 >= busy8.size()) begin
            failCount++;
            $display("[TB] FAIL busy_window: start %0d samples %0d, want 11 periods from start", s, busy8.size());
        end else if (busy8[s+9] !== 1'b1 || busy8[s+10] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL busy_fall: got %b%b want 10", busy8[s+9], busy8[s+10]);
        end
        assertCount++;
        if (d8Empty !== 1'b1 || d8Busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL idle_after_a5: empty %b busy %b want 1 0", d8Empty, d8Busy);
        end
    endtask

    task automatic test_parity();
        bitq_t expE, expO;
        int    d;
        expE = frameBits(7'h41, 7, 2, 2);
        expO = frameBits(7'h41, 7, 1, 2);
        waitCnt(0);
        @(negedge clk_50m);
        clearCaps();
        d7Data = 7'h41;
        d7Wr   = 1'b1;
        @(negedge clk_50m);
        d7Wr   = 1'b0;
        repeat (14 * 16) @(negedge clk_50m);
        d = streamDiff(capE, expE, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL frame_7e2: first bad sample %0d, want none (-1)", d); end
        d = streamDiff(capO, expO, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL frame_7o2: first bad sample %0d, want none (-1)", d); end
        assertCount++;
        if (eBusy !== 1'b0 || oBusy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL idle_after_7x2: busy %b%b want 00", eBusy, oBusy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [5];
        bitq_t      expQ, fb;
        int         d, expLvl;
        for (int i = 0; i < 5; i++) words[i] = 8'($urandom_range(0, 255));
        waitCnt(0);
        @(negedge clk_50m);
        clearCaps();
        for (int i = 0; i < 5; i++) begin
            d8Data = words[i];
            d8Wr   = 1'b1;
            @(negedge clk_50m);
            expLvl = (i < 4) ? i + 1 : 4;
            assertCount++;
            if (d8Level !== 3'(expLvl)) begin
                failCount++;
                $display("[TB] FAIL b2b_level_%0d: got %0d want %0d", i, d8Level, expLvl);
            end
            assertCount++;
            if (d8Full !== ((i >= 3) ? 1'b1 : 1'b0)) begin
                failCount++;
                $display("[TB] FAIL b2b_full_%0d: got %b want %0d", i, d8Full, (i >= 3));
            end
            assertCount++;
            if (d8Ovf !== ((i == 4) ? 1'b1 : 1'b0)) begin
                failCount++;
                $display("[TB] FAIL b2b_overflow_%0d: got %b want %0d", i, d8Ovf, (i == 4));
            end
        end
        d8Wr = 1'b0;
        @(negedge clk_50m);
        assertCount++;
        if (d8Ovf !== 1'b0 || d8Level !== 3'd4) begin
            failCount++;
            $display("[TB] FAIL b2b_pulse_end: overflow %b level %0d want 0 4", d8Ovf, d8Level);
        end
        for (int i = 0; i < 4; i++) begin
            fb = frameBits(words[i], 8, 0, 1);
            foreach (fb[k]) expQ.push_back(fb[k]);
        end
        repeat (44 * 16) @(negedge clk_50m);
        d = streamDiff(cap8, expQ, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL b2b_frames: first bad sample %0d, want none (-1)", d); end
        assertCount++;
        if (d8Empty !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_drained: empty %b want 1", d8Empty); end
    endtask

    task automatic test_full_pop();
        logic [7:0] words [4];
        logic [7:0] dropped;
        bitq_t      expQ, fb;
        int         d;
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom_range(0, 255));
        dropped = 8'($urandom_range(0, 255));
        waitCnt(0);
        @(negedge clk_50m);
        clearCaps();
        for (int i = 0; i < 4; i++) begin
            d8Data = words[i];
            d8Wr   = 1'b1;
            @(negedge clk_50m);
        end
        d8Wr = 1'b0;
        assertCount++;
        if (d8Full !== 1'b1 || d8Busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL fullpop_setup: full %b busy %b want 1 0", d8Full, d8Busy);
        end
        waitCnt(clkDiv - 1);
        d8Data = dropped;
        d8Wr   = 1'b1;
        @(negedge clk_50m);
        d8Wr   = 1'b0;
        assertCount++;
        if (d8Ovf !== 1'b1) begin failCount++; $display("[TB] FAIL fullpop_overflow: got %b want 1", d8Ovf); end
        assertCount++;
        if (d8Level !== 3'd3) begin failCount++; $display("[TB] FAIL fullpop_level: got %0d want 3", d8Level); end
        assertCount++;
        if (d8Full !== 1'b0 || d8Busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL fullpop_state: full %b busy %b want 0 1", d8Full, d8Busy);
        end
        for (int i = 0; i < 4; i++) begin
            fb = frameBits(words[i], 8, 0, 1);
            foreach (fb[k]) expQ.push_back(fb[k]);
        end
        repeat (44 * 16) @(negedge clk_50m);
        d = streamDiff(cap8, expQ, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL fullpop_frames: first bad sample %0d, want none (-1)", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w0, w1, w2;
        bitq_t      expQ;
        int         d;
        w0 = 8'($urandom_range(0, 255));
        w1 = 8'($urandom_range(0, 255));
        w2 = 8'($urandom_range(0, 255));
        waitCnt(0);
        @(negedge clk_50m);
        clearCaps();
        d8Data = w0;
        d8Wr   = 1'b1;
        @(negedge clk_50m);
        d8Data = w1;
        @(negedge clk_50m);
        d8Wr   = 1'b0;
        for (int g = 0; g < 200 && cap8.size() < 5; g++) @(negedge clk_50m);
        assertCount++;
        if (cap8.size() < 5 || d8Busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midframe_reach: periods %0d busy %b want >=5 and 1", cap8.size(), d8Busy);
        end
        rst_n = 1'b0;
        #2;
        assertCount++;
        if (d8Tx !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_tx: got %b want 1", d8Tx); end
        assertCount++;
        if (d8Busy !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_busy: got %b want 0", d8Busy); end
        assertCount++;
        if (d8Empty !== 1'b1 || d8Level !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL midreset_queue: empty %b level %0d want 1 0", d8Empty, d8Level);
        end
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        waitCnt(1);
        clearCaps();
        repeat (3 * 16) @(negedge clk_50m);
        d8Data = w2;
        d8Wr   = 1'b1;
        @(negedge clk_50m);
        d8Wr   = 1'b0;
        repeat (12 * 16) @(negedge clk_50m);
        expQ = frameBits(w2, 8, 0, 1);
        d = streamDiff(cap8, expQ, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL postreset_frame: first bad sample %0d, want none (-1)", d); end
    endtask

    task automatic test_fast_clken();
        bitq_t      expQ, fb;
        logic [7:0] w;
        int         d, gap;
        waitCnt(1);
        clearCaps();
        clkDiv = 1;
        @(negedge clk_50m);
        d8Data = 8'h00;
        d8Wr   = 1'b1;
        @(negedge clk_50m);
        d8Data = 8'hFF;
        @(negedge clk_50m);
        d8Wr   = 1'b0;
        fb = frameBits(8'h00, 8, 0, 1);
        foreach (fb[k]) expQ.push_back(fb[k]);
        fb = frameBits(8'hFF, 8, 0, 1);
        foreach (fb[k]) expQ.push_back(fb[k]);
        repeat (40) @(negedge clk_50m);
        d = streamDiff(cap8, expQ, 0);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL fast_00_ff: first bad sample %0d, want none (-1)", d); end
        clearCaps();
        expQ.delete();
        for (int i = 0; i < 6; i++) begin
            w      = 8'($urandom_range(0, 255));
            gap    = $urandom_range(4, 14);
            d8Data = w;
            d8Wr   = 1'b1;
            @(negedge clk_50m);
            d8Wr   = 1'b0;
            repeat (gap) @(negedge clk_50m);
            fb = frameBits(w, 8, 0, 1);
            foreach (fb[k]) expQ.push_back(fb[k]);
        end
        repeat (80) @(negedge clk_50m);
        d = streamDiff(cap8, expQ, 10);
        assertCount++;
        if (d !== -1) begin failCount++; $display("[TB] FAIL fast_random: first bad sample %0d, want none (-1)", d); end
        assertCount++;
        if (d8Empty !== 1'b1 || d8Busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL fast_drained: empty %b busy %b want 1 0", d8Empty, d8Busy);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        d8Wr   = 1'b0;
        d7Wr   = 1'b0;
        d8Data = '0;
        d7Data = '0;
        test_reset();
        test_frame_8n1();
        test_parity();
        test_back_to_back();
        test_full_pop();
        test_reset_mid_frame();
        test_fast_clken();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
